// File: rtl/count_check_pkg.sv
// Shared definitions for the counter-pair checker: FSM state encoding,
// the error counter ceiling and a saturating add helper.
package count_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BASE = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] ERR_MAX = 8'd255;

    // Adds 0..2 to an 8-bit error count, clamping at ERR_MAX instead of wrapping
    function automatic logic [7:0] satAdd(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, inc};
        return (sum > {1'b0, ERR_MAX}) ? ERR_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/step_checker.sv
// One independent expectation model for a single counter. The expectation
// is loaded once from the observed value and then only steps by DIR, so a
// glitched observation never pulls the model off course.
module step_checker #(
    parameter int WIDTH = 8,
    parameter int DIR   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_val,
    output logic             o_mismatch
);

    localparam logic [WIDTH-1:0] STEP = (DIR >= 0) ? WIDTH'(1) : '1;

    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] w_next;

    assign w_next = r_exp + STEP;

    // Case-inequality so unknown bits on the observed value count as a miss
    assign o_mismatch = i_step && (i_val !== w_next);

    // Baseline capture on load, free-running modular step on every check cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp <= '0;
        end else if (i_load) begin
            r_exp <= i_val;
        end else if (i_step) begin
            r_exp <= w_next;
        end
    end

endmodule

// File: rtl/count_pair_checker.sv
// Watches an incrementing and a decrementing counter for a fixed number of
// samples after a baseline capture and reports a saturating mismatch count.
module count_pair_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_SAMPLES = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] up_val,
    input  logic [WIDTH-1:0] dn_val,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_cnt,
    output logic [WIDTH-1:0] up_last,
    output logic [WIDTH-1:0] dn_last
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_SAMPLES - 1);

    state_t           r_state;
    logic [7:0]       r_sampleCnt;
    logic [7:0]       r_errCnt;
    logic [WIDTH-1:0] r_upLast;
    logic [WIDTH-1:0] r_dnLast;

    logic             w_load;
    logic             w_step;
    logic             w_upMis;
    logic             w_dnMis;
    logic             w_lastSample;
    logic [7:0]       w_errNext;

    assign w_load       = (r_state == ST_BASE);
    assign w_step       = (r_state == ST_RUN);
    assign w_lastSample = (r_sampleCnt == LAST_IDX);
    assign w_errNext    = satAdd(r_errCnt, {1'b0, w_upMis} + {1'b0, w_dnMis});

    if (WIDTH > 0) begin : UP_CHK
        step_checker #(
            .WIDTH (WIDTH),
            .DIR   (1)
        ) u_chk (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_load),
            .i_step     (w_step),
            .i_val      (up_val),
            .o_mismatch (w_upMis)
        );
    end

    if (WIDTH > 0) begin : DN_CHK
        step_checker #(
            .WIDTH (WIDTH),
            .DIR   (-1)
        ) u_chk (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_load),
            .i_step     (w_step),
            .i_val      (dn_val),
            .o_mismatch (w_dnMis)
        );
    end

    // Run sequencing: start clears results, BASE is one cycle, RUN counts checks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sampleCnt <= '0;
            r_errCnt    <= '0;
            r_upLast    <= '0;
            r_dnLast    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_BASE;
                        r_sampleCnt <= '0;
                        r_errCnt    <= '0;
                        r_upLast    <= '0;
                        r_dnLast    <= '0;
                    end
                end
                ST_BASE: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_errCnt    <= w_errNext;
                    r_sampleCnt <= r_sampleCnt + 8'd1;
                    if (w_lastSample) begin
                        r_state  <= ST_DONE;
                        r_upLast <= up_val;
                        r_dnLast <= dn_val;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == ST_BASE) || (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign pass    = done && (r_errCnt == 8'd0);
    assign err_cnt = r_errCnt;
    assign up_last = r_upLast;
    assign dn_last = r_dnLast;

endmodule

// File: tb/tb_count_pair_checker.sv
// Randomized scoreboard bench for count_pair_checker. Each run's observed
// sequence is planned up front, the expected result is derived from the
// counting rules and queued, and a monitor compares when done rises.
module tb_count_pair_checker;

    localparam int W  = 8;
    localparam int N  = 9;
    localparam int N2 = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] up_val;
    logic [W-1:0] dn_val;
    logic         busy;
    logic         done;
    logic         pass;
    logic [7:0]   err_cnt;
    logic [W-1:0] up_last;
    logic [W-1:0] dn_last;

    logic         start2;
    logic [W-1:0] up2;
    logic [W-1:0] dn2;
    logic         busy2;
    logic         done2;
    logic         pass2;
    logic [7:0]   errCnt2;
    logic [W-1:0] upLast2;
    logic [W-1:0] dnLast2;

    typedef struct {
        int           doneEdge;
        logic [7:0]   err;
        logic         pass;
        logic [W-1:0] upLast;
        logic [W-1:0] dnLast;
    } exp_t;

    exp_t         sbq[$];
    int           compared   = 0;
    int           mismatched = 0;
    int           cycleCnt   = 0;
    logic         doneQ      = 1'b0;
    logic [W-1:0] upSeq[0:N];
    logic [W-1:0] dnSeq[0:N];

    count_pair_checker #(.WIDTH(W), .NUM_SAMPLES(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .up_val  (up_val),
        .dn_val  (dn_val),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .up_last (up_last),
        .dn_last (dn_last)
    );

    count_pair_checker #(.WIDTH(W), .NUM_SAMPLES(N2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start2),
        .up_val  (up2),
        .dn_val  (dn2),
        .busy    (busy2),
        .done    (done2),
        .pass    (pass2),
        .err_cnt (errCnt2),
        .up_last (upLast2),
        .dn_last (dnLast2)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used to timestamp start sampling and done arrival
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: on each rising done, pop the oldest expectation and compare
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done && !doneQ) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending run");
            end else begin
                e = sbq.pop_front();
                checkOutput("done_latency", 32'(cycleCnt), 32'(e.doneEdge));
                checkOutput("err_cnt", 32'(err_cnt), 32'(e.err));
                checkOutput("pass", 32'(pass), 32'(e.pass));
                checkOutput("up_last", 32'(up_last), 32'(e.upLast));
                checkOutput("dn_last", 32'(dn_last), 32'(e.dnLast));
                checkOutput("busy_in_done", 32'(busy), 32'd0);
            end
        end
        doneQ = done;
    end

    // Plans one run's observed values by mode, derives the expected result
    // from the counting rules, then drives it; pulseAt>0 pokes start mid-run
    task automatic applyStimulus(input int mode, input int pulseAt);
        logic [W-1:0] bu;
        logic [W-1:0] bd;
        logic [W-1:0] g;
        int           errs;
        int           gi;
        int           guard;
        exp_t         e;
        bu = W'($urandom);
        bd = W'($urandom);
        if (mode == 1) begin
            bu = 8'hFE;
            bd = 8'h01;
        end
        if (mode == 6) begin
            bu = 8'h00;
            bd = 8'h00;
        end
        for (int i = 0; i <= N; i++) begin
            upSeq[i] = bu + W'(i);
            dnSeq[i] = bd - W'(i);
        end
        case (mode)
            2: begin
                if (upSeq[4] == 8'h55) begin
                    for (int i = 0; i <= N; i++) upSeq[i] = upSeq[i] + W'(1);
                end
                upSeq[4] = 8'h55;
            end
            3: for (int i = 0; i <= N; i++) dnSeq[i] = 8'h00;
            4: for (int i = 1; i <= N; i++) begin
                if ($urandom_range(3) == 0) upSeq[i] = W'($urandom);
                if ($urandom_range(3) == 0) dnSeq[i] = W'($urandom);
            end
            5: begin
                gi = $urandom_range(N, 1);
                g = W'($urandom_range(255, 1));
                upSeq[gi] = upSeq[gi] + g;
                dnSeq[gi] = dnSeq[gi] ^ g;
            end
            default: ;
        endcase
        errs = 0;
        for (int i = 1; i <= N; i++) begin
            if (upSeq[i] !== W'(upSeq[0] + W'(i))) errs++;
            if (dnSeq[i] !== W'(dnSeq[0] - W'(i))) errs++;
        end
        e.err    = (errs > 255) ? 8'd255 : 8'(errs);
        e.pass   = (errs == 0);
        e.upLast = upSeq[N];
        e.dnLast = dnSeq[N];

        @(negedge clk);
        start  = 1'b1;
        up_val = W'($urandom);
        dn_val = W'($urandom);
        e.doneEdge = cycleCnt + N + 2;
        sbq.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        up_val = upSeq[0];
        dn_val = dnSeq[0];
        for (int i = 1; i <= N; i++) begin
            @(negedge clk);
            checkOutput("busy_run", 32'(busy), 32'd1);
            checkOutput("done_run", 32'(done), 32'd0);
            start  = (i == pulseAt);
            up_val = upSeq[i];
            dn_val = dnSeq[i];
        end
        @(negedge clk);
        start  = 1'b0;
        up_val = W'($urandom);
        dn_val = W'($urandom);
        guard = 0;
        while (sbq.size() != 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done_timeout: got no done in 30 cycles, expected done");
            sbq.delete();
        end
        repeat ($urandom_range(3, 1)) @(negedge clk);
        checkOutput("done_hold", 32'(done), 32'd1);
        checkOutput("err_hold", 32'(err_cnt), 32'(e.err));
    endtask

    // Starts a run and asserts reset during its fifth check cycle
    task automatic abortRun();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        up_val = 8'h10;
        dn_val = 8'h20;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            up_val = 8'h90;
            dn_val = 8'h90;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_pass", 32'(pass), 32'd0);
        checkOutput("abort_err", 32'(err_cnt), 32'd0);
        checkOutput("abort_up_last", 32'(up_last), 32'd0);
        checkOutput("abort_dn_last", 32'(dn_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
    endtask

    // Long run with both counters stuck so the error count must clamp
    task automatic runSaturation();
        int guard;
        int errs;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        up2 = 8'h33;
        dn2 = 8'h33;
        errs = 2 * N2;
        repeat (N2 + 1) @(negedge clk);
        guard = 0;
        while (!done2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("sat_done", 32'(done2), 32'd1);
        checkOutput("sat_err", 32'(errCnt2), 32'((errs > 255) ? 255 : errs));
        checkOutput("sat_pass", 32'(pass2), 32'd0);
        checkOutput("sat_up_last", 32'(upLast2), 32'h33);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        up_val = '0;
        dn_val = '0;
        start2 = 1'b0;
        up2    = '0;
        dn2    = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_err", 32'(err_cnt), 32'd0);
        checkOutput("rst_up_last", 32'(up_last), 32'd0);
        checkOutput("rst_dn_last", 32'(dn_last), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(6, 0);
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        applyStimulus(3, 0);
        applyStimulus(5, 0);
        applyStimulus(4, 0);
        applyStimulus(0, 3);
        abortRun();
        applyStimulus(6, 0);
        for (int r = 0; r < 20; r++) begin
            applyStimulus(int'($urandom_range(6)), int'($urandom_range(N)));
        end
        runSaturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
